elevator_request_scheduler: RTL and testbench

- Upstream stage of the elevator controller.
- Latches per-floor call buttons into a pending-request register and picks the next target floor with a direction-preserving (SCAN) policy.
- Drives that target onto the elevator's i_buttons input and watches the elevator's o_current_floor to detect arrival.
- Holds a door-open dwell at each served floor before choosing the next target.

---
 rtl/elevator_request_scheduler.sv | 150 +++++++++++++++
 tb/tb_elevator_request_scheduler.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/elevator_request_scheduler.sv
// Elevator request scheduler: latches floor calls and feeds SCAN-ordered targets to the
// elevator, holding a door-open dwell at every served floor.
module elevator_request_scheduler #(
   parameter int NUM_FLOORS   = 4,
   parameter int FLOOR_W      = 2,
   parameter int DWELL_CYCLES = 8
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic [NUM_FLOORS-1:0] i_call,
   input  logic [FLOOR_W-1:0]    i_current_floor,
   output logic [FLOOR_W-1:0]    o_target_floor,
   output logic [NUM_FLOORS-1:0] o_pending,
   output logic                  o_dir_up,
   output logic                  o_door_open,
   output logic                  o_busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MOVING = 2'd1,
      DWELL  = 2'd2
   } state_t;

   localparam logic [7:0] DWELL_LOAD = 8'(DWELL_CYCLES);

   state_t                state_q, state_d;
   logic [NUM_FLOORS-1:0] pending_q, pending_d;
   logic [NUM_FLOORS-1:0] call_prev_q, call_prev_d;
   logic [NUM_FLOORS-1:0] set_mask, clr_mask;
   logic [FLOOR_W-1:0]    target_q, target_d;
   logic                  dir_up_q, dir_up_d;
   logic [7:0]            cnt_q, cnt_d;

   logic                  up_valid, dn_valid, ahead_valid, behind_valid;
   logic [FLOOR_W-1:0]    up_floor, dn_floor, ahead_floor, behind_floor;

   // Nearest pending floor strictly above and strictly below the car.
   always_comb begin
      up_valid = 1'b0;
      up_floor = '0;
      dn_valid = 1'b0;
      dn_floor = '0;
      for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
         if (pending_q[f] && (f > int'(i_current_floor))) begin
            up_valid = 1'b1;
            up_floor = FLOOR_W'(f);
         end
      end
      for (int f = 0; f < NUM_FLOORS; f++) begin
         if (pending_q[f] && (f < int'(i_current_floor))) begin
            dn_valid = 1'b1;
            dn_floor = FLOOR_W'(f);
         end
      end
      ahead_valid  = dir_up_q ? up_valid : dn_valid;
      ahead_floor  = dir_up_q ? up_floor : dn_floor;
      behind_valid = dir_up_q ? dn_valid : up_valid;
      behind_floor = dir_up_q ? dn_floor : up_floor;
   end

   always_comb begin
      state_d     = state_q;
      target_d    = target_q;
      dir_up_d    = dir_up_q;
      cnt_d       = cnt_q;
      call_prev_d = i_call;
      set_mask    = i_call & ~call_prev_q;
      clr_mask    = '0;

      unique case (state_q)
         IDLE: begin
            target_d = i_current_floor;
            if (pending_q[i_current_floor]) begin
               clr_mask[i_current_floor] = 1'b1;
               cnt_d   = DWELL_LOAD;
               state_d = DWELL;
            end else if (|pending_q) begin
               if (ahead_valid) begin
                  target_d = ahead_floor;
               end else begin
                  target_d = behind_floor;
                  dir_up_d = ~dir_up_q;
               end
               state_d = MOVING;
            end
         end
         MOVING: begin
            if (i_current_floor == target_q) begin
               clr_mask[target_q] = 1'b1;
               cnt_d   = DWELL_LOAD;
               state_d = DWELL;
            end else if (ahead_valid &&
                         (dir_up_q ? (ahead_floor < target_q) : (ahead_floor > target_q))) begin
               target_d = ahead_floor;
            end
         end
         DWELL: begin
            // Calls for the floor whose door is already open are simply absorbed.
            set_mask[i_current_floor] = 1'b0;
            cnt_d = cnt_q - 8'd1;
            if (cnt_q <= 8'd1) begin
               if (ahead_valid) begin
                  target_d = ahead_floor;
                  state_d  = MOVING;
               end else if (behind_valid) begin
                  target_d = behind_floor;
                  dir_up_d = ~dir_up_q;
                  state_d  = MOVING;
               end else if (pending_q[i_current_floor]) begin
                  clr_mask[i_current_floor] = 1'b1;
                  target_d = i_current_floor;
                  cnt_d    = DWELL_LOAD;
               end else begin
                  target_d = i_current_floor;
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      pending_d = (pending_q | set_mask) & ~clr_mask;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         call_prev_q <= '0;
         target_q    <= '0;
         dir_up_q    <= 1'b1;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         call_prev_q <= call_prev_d;
         target_q    <= target_d;
         dir_up_q    <= dir_up_d;
         cnt_q       <= cnt_d;
      end
   end

   assign o_target_floor = target_q;
   assign o_pending      = pending_q;
   assign o_dir_up       = dir_up_q;
   assign o_door_open    = (state_q == DWELL);
   assign o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler: per-cycle expectations are queued with the
// stimulus and popped/compared half a cycle after the clock edge that produces them.
module tb_elevator_request_scheduler;

   logic       i_clock = 1'b0;
   logic       i_reset;
   logic [3:0] i_call;
   logic [1:0] i_current_floor;
   logic [1:0] o_target_floor;
   logic [3:0] o_pending;
   logic       o_dir_up;
   logic       o_door_open;
   logic       o_busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string      tag;
      logic [3:0] pend;
      logic [1:0] tgt;
      logic       dir;
      logic       door;
      logic       busy;
   } exp_t;

   exp_t sb[$];

   elevator_request_scheduler #(
      .NUM_FLOORS  (4),
      .FLOOR_W     (2),
      .DWELL_CYCLES(8)
   ) dut (
      .i_clock        (i_clock),
      .i_reset        (i_reset),
      .i_call         (i_call),
      .i_current_floor(i_current_floor),
      .o_target_floor (o_target_floor),
      .o_pending      (o_pending),
      .o_dir_up       (o_dir_up),
      .o_door_open    (o_door_open),
      .o_busy         (o_busy)
   );

   always #5 i_clock = ~i_clock;

   // Queue the expected post-edge outputs, drive the inputs, and wait until the next falling edge.
   task automatic applyStimulus(input string tag, input logic rst, input logic [3:0] call,
                                input logic [1:0] floor, input logic [3:0] pend,
                                input logic [1:0] tgt, input logic dir, input logic door,
                                input logic busy);
      exp_t e;
      e.tag  = tag;
      e.pend = pend;
      e.tgt  = tgt;
      e.dir  = dir;
      e.door = door;
      e.busy = busy;
      sb.push_back(e);
      i_reset         = rst;
      i_call          = call;
      i_current_floor = floor;
      @(negedge i_clock);
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $error("[TB] FAIL scoreboard_empty observed=0 entries expected>=1");
         return;
      end
      e = sb.pop_front();
      checks++;
      assert (o_pending === e.pend) else begin
         failures++;
         $error("[TB] FAIL %s pending observed=%b expected=%b", e.tag, o_pending, e.pend);
      end
      checks++;
      assert (o_target_floor === e.tgt) else begin
         failures++;
         $error("[TB] FAIL %s target observed=%0d expected=%0d", e.tag, o_target_floor, e.tgt);
      end
      checks++;
      assert (o_dir_up === e.dir) else begin
         failures++;
         $error("[TB] FAIL %s dir_up observed=%b expected=%b", e.tag, o_dir_up, e.dir);
      end
      checks++;
      assert (o_door_open === e.door) else begin
         failures++;
         $error("[TB] FAIL %s door_open observed=%b expected=%b", e.tag, o_door_open, e.door);
      end
      checks++;
      assert (o_busy === e.busy) else begin
         failures++;
         $error("[TB] FAIL %s busy observed=%b expected=%b", e.tag, o_busy, e.busy);
      end
   endtask

   task automatic cyc(input string tag, input logic rst, input logic [3:0] call,
                      input logic [1:0] floor, input logic [3:0] pend, input logic [1:0] tgt,
                      input logic dir, input logic door, input logic busy);
      applyStimulus(tag, rst, call, floor, pend, tgt, dir, door, busy);
      checkOutput();
   endtask

   initial begin
      // Reset and idle.
      cyc("reset0", 1'b1, 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
      cyc("reset1", 1'b1, 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++)
         cyc("idle", 1'b0, 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);

      // Single call to floor 3 from floor 0; a fresh call edge on arrival is cleared.
      cyc("call3_edge",   1'b0, 4'b1000, 2'd0, 4'b1000, 2'd0, 1'b1, 1'b0, 1'b0);
      cyc("call3_target", 1'b0, 4'b0000, 2'd0, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);
      cyc("move_f1",      1'b0, 4'b0000, 2'd1, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);
      cyc("move_f2",      1'b0, 4'b0000, 2'd2, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);
      cyc("arrive3",      1'b0, 4'b1000, 2'd3, 4'b0000, 2'd3, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++)
         cyc("dwell3", 1'b0, 4'b0000, 2'd3, 4'b0000, 2'd3, 1'b1, 1'b1, 1'b1);
      cyc("dwell3_exit",  1'b0, 4'b0000, 2'd3, 4'b0000, 2'd3, 1'b1, 1'b0, 1'b0);

      // Retarget to a closer floor while moving up.
      cyc("idle_f0",    1'b0, 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
      cyc("rt_call3",   1'b0, 4'b1000, 2'd0, 4'b1000, 2'd0, 1'b1, 1'b0, 1'b0);
      cyc("rt_target3", 1'b0, 4'b0000, 2'd0, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);
      cyc("rt_call2",   1'b0, 4'b0100, 2'd0, 4'b1100, 2'd3, 1'b1, 1'b0, 1'b1);
      cyc("rt_target2", 1'b0, 4'b0000, 2'd0, 4'b1100, 2'd2, 1'b1, 1'b0, 1'b1);
      cyc("rt_f1",      1'b0, 4'b0000, 2'd1, 4'b1100, 2'd2, 1'b1, 1'b0, 1'b1);
      cyc("rt_arrive2", 1'b0, 4'b0000, 2'd2, 4'b1000, 2'd2, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++)
         cyc("dwell2", 1'b0, 4'b0000, 2'd2, 4'b1000, 2'd2, 1'b1, 1'b1, 1'b1);
      cyc("rt_next3",   1'b0, 4'b0000, 2'd2, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);

      // Reversal: floor 0 requested behind while heading up to 3.
      cyc("rev_call0",   1'b0, 4'b0001, 2'd2, 4'b1001, 2'd3, 1'b1, 1'b0, 1'b1);
      cyc("rev_hold",    1'b0, 4'b0000, 2'd2, 4'b1001, 2'd3, 1'b1, 1'b0, 1'b1);
      cyc("rev_arrive3", 1'b0, 4'b1000, 2'd3, 4'b0001, 2'd3, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++)
         cyc("dwell3b", 1'b0, 4'b0000, 2'd3, 4'b0001, 2'd3, 1'b1, 1'b1, 1'b1);
      cyc("rev_target0", 1'b0, 4'b0000, 2'd3, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b1);
      cyc("rev_f2",      1'b0, 4'b0000, 2'd2, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b1);
      cyc("rev_f1",      1'b0, 4'b0000, 2'd1, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b1);
      cyc("rev_arrive0", 1'b0, 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++)
         cyc("dwell0", 1'b0, 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1);
      cyc("rev_idle",    1'b0, 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

      // Call at the current floor; a repeat call during the dwell must not extend it.
      cyc("cur_idle_f1", 1'b0, 4'b0000, 2'd1, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);
      cyc("cur_call1",   1'b0, 4'b0010, 2'd1, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b0);
      cyc("cur_dwell",   1'b0, 4'b0000, 2'd1, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b1);
      cyc("cur_recall",  1'b0, 4'b0010, 2'd1, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++)
         cyc("cur_dwell1", 1'b0, 4'b0000, 2'd1, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b1);
      cyc("cur_exit",    1'b0, 4'b0000, 2'd1, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);

      // Reset while moving, with a call button held through the reset.
      cyc("rs_call",      1'b0, 4'b1010, 2'd0, 4'b1010, 2'd0, 1'b0, 1'b0, 1'b0);
      cyc("rs_move",      1'b0, 4'b0000, 2'd0, 4'b1010, 2'd1, 1'b1, 1'b0, 1'b1);
      cyc("rs_reset",     1'b1, 4'b0100, 2'd0, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
      cyc("rs_held_edge", 1'b0, 4'b0100, 2'd0, 4'b0100, 2'd0, 1'b1, 1'b0, 1'b0);
      cyc("rs_held_tgt",  1'b0, 4'b0100, 2'd0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
      cyc("rs_f1",        1'b0, 4'b0100, 2'd1, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
      cyc("rs_arrive2",   1'b0, 4'b0100, 2'd2, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b1);
      cyc("rs_held_once", 1'b0, 4'b0100, 2'd2, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
